// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vm_pkg
// Purpose  : Shared vending-machine constants, tube indices and dispenser states
// Revision : 1.0 - initial release
// ============================================================================
package vm_pkg;

   localparam int COIN1 = 1;
   localparam int COIN2 = 2;
   localparam int COIN5 = 5;

   localparam int TUBE5 = 2;
   localparam int TUBE2 = 1;
   localparam int TUBE1 = 0;

   typedef enum logic [2:0] {
      DS_IDLE     = 3'd0,
      DS_SELECT   = 3'd1,
      DS_EJECT    = 3'd2,
      DS_WAIT_ACK = 3'd3,
      DS_GAP      = 3'd4,
      DS_DONE     = 3'd5,
      DS_FAULT    = 3'd6
   } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/coin_select.sv
`default_nettype none
// ============================================================================
// Module   : coin_select
// Purpose  : Combinational greedy chooser of the largest stocked coin <= remaining
// Revision : 1.0 - initial release
// ============================================================================
module coin_select
   import vm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic [CNT_W-1:0] remaining_i,
   input  logic [2:0]       hopper_empty_i,
   output logic             valid_o,
   output logic [2:0]       tube_o,
   output logic [CNT_W-1:0] denom_o
);

   // tube and denom read as zero whenever no coin can be paid
   always_comb begin
      valid_o = 1'b0;
      tube_o  = 3'b000;
      denom_o = '0;
      if ((remaining_i >= CNT_W'(COIN5)) && !hopper_empty_i[TUBE5]) begin
         valid_o       = 1'b1;
         tube_o[TUBE5] = 1'b1;
         denom_o       = CNT_W'(COIN5);
      end else if ((remaining_i >= CNT_W'(COIN2)) && !hopper_empty_i[TUBE2]) begin
         valid_o       = 1'b1;
         tube_o[TUBE2] = 1'b1;
         denom_o       = CNT_W'(COIN2);
      end else if ((remaining_i >= CNT_W'(COIN1)) && !hopper_empty_i[TUBE1]) begin
         valid_o       = 1'b1;
         tube_o[TUBE1] = 1'b1;
         denom_o       = CNT_W'(COIN1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : coin_dispenser
// Purpose  : Pays a change amount as timed eject strobes to a 5/2/1 coin hopper
// Revision : 1.0 - initial release
// ============================================================================
module coin_dispenser
   import vm_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 4,
   parameter int ACK_TIMEOUT  = 1000,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_dispense,
   input  logic [CNT_W-1:0] amount,
   input  logic [2:0]       hopper_empty,
   input  logic             coin_ack,
   output logic [2:0]       eject,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [CNT_W-1:0] remaining,
   output logic [CNT_W-1:0] coins_paid
);

   localparam int PH_MAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int PH_W    = $clog2(PH_MAX + 1);
   localparam int TMR_MAX = (ACK_TIMEOUT > PULSE_CYCLES) ? ACK_TIMEOUT : PULSE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   disp_state_e      state_q, state_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [2:0]       tube_q, tube_d;
   logic [CNT_W-1:0] denom_q, denom_d;
   logic             ack_q, ack_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] paid_q, paid_d;
   logic [2:0]       eject_q, eject_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;

   logic             w_sel_valid;
   logic [2:0]       w_sel_tube;
   logic [CNT_W-1:0] w_sel_denom;

   coin_select #(.CNT_W(CNT_W)) u_coin_select (
      .remaining_i    (remaining_q),
      .hopper_empty_i (hopper_empty),
      .valid_o        (w_sel_valid),
      .tube_o         (w_sel_tube),
      .denom_o        (w_sel_denom)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      timer_d     = timer_q;
      tube_d      = tube_q;
      denom_d     = denom_q;
      ack_d       = ack_q;
      remaining_d = remaining_q;
      paid_d      = paid_q;
      fault_d     = fault_q;

      case (state_q)
         DS_IDLE, DS_FAULT: begin
            if (start_dispense) begin
               remaining_d = amount;
               paid_d      = '0;
               fault_d     = 1'b0;
               state_d     = DS_SELECT;
            end
         end
         DS_SELECT: begin
            if (remaining_q == '0) begin
               state_d = DS_DONE;
            end else if (w_sel_valid) begin
               tube_d  = w_sel_tube;
               denom_d = w_sel_denom;
               phase_d = '0;
               timer_d = '0;
               ack_d   = 1'b0;
               state_d = DS_EJECT;
            end else begin
               fault_d = 1'b1;
               state_d = DS_FAULT;
            end
         end
         DS_EJECT: begin
            timer_d = timer_q + TMR_W'(1);
            phase_d = phase_q + PH_W'(1);
            if (phase_q == PH_W'(PULSE_CYCLES - 1)) begin
               state_d = DS_WAIT_ACK;
            end
         end
         DS_WAIT_ACK: begin
            timer_d = timer_q + TMR_W'(1);
            if (ack_q || coin_ack) begin
               phase_d = '0;
               state_d = DS_GAP;
            end else if (timer_q >= TMR_W'(ACK_TIMEOUT - 1)) begin
               fault_d = 1'b1;
               state_d = DS_FAULT;
            end
         end
         DS_GAP: begin
            phase_d = phase_q + PH_W'(1);
            if (phase_q == PH_W'(GAP_CYCLES - 1)) begin
               state_d = DS_SELECT;
            end
         end
         DS_DONE: begin
            state_d = DS_IDLE;
         end
         default: begin
            state_d = DS_IDLE;
         end
      endcase

      // only the first acknowledge of a coin is booked; repeats are dropped
      if (((state_q == DS_EJECT) || (state_q == DS_WAIT_ACK)) && coin_ack && !ack_q) begin
         ack_d       = 1'b1;
         remaining_d = remaining_q - denom_q;
         paid_d      = (&paid_q) ? paid_q : paid_q + CNT_W'(1);
      end

      eject_d = (state_d == DS_EJECT) ? tube_d : 3'b000;
      busy_d  = (state_d == DS_SELECT) || (state_d == DS_EJECT) ||
                (state_d == DS_WAIT_ACK) || (state_d == DS_GAP);
      done_d  = (state_d == DS_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DS_IDLE;
         phase_q     <= '0;
         timer_q     <= '0;
         tube_q      <= 3'b000;
         denom_q     <= '0;
         ack_q       <= 1'b0;
         remaining_q <= '0;
         paid_q      <= '0;
         eject_q     <= 3'b000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         timer_q     <= timer_d;
         tube_q      <= tube_d;
         denom_q     <= denom_d;
         ack_q       <= ack_d;
         remaining_q <= remaining_d;
         paid_q      <= paid_d;
         eject_q     <= eject_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
      end
   end

   assign eject      = eject_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign remaining  = remaining_q;
   assign coins_paid = paid_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_dispenser
// Purpose  : Self-checking bench for coin_dispenser and its coin_select chooser
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_dispenser;

   localparam int CNT_W = 8;
   localparam int PULSE = 4;
   localparam int GAP   = 4;
   localparam int TMO   = 50;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_dispense;
   logic [CNT_W-1:0] amount;
   logic [2:0]       hopper_empty;
   logic             coin_ack;
   logic [2:0]       eject;
   logic             busy;
   logic             done;
   logic             fault;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] coins_paid;

   logic [CNT_W-1:0] sel_rem;
   logic [2:0]       sel_empty;
   logic             sel_valid;
   logic [2:0]       sel_tube;
   logic [CNT_W-1:0] sel_denom;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0] ej;
      int         rem;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int         rem;
      logic [2:0] empty;
      logic       valid;
      logic [2:0] tube;
      int         denom;
   } vec_t;
   vec_t vecs[14];

   always #5 clk = ~clk;

   coin_dispenser #(
      .PULSE_CYCLES (PULSE),
      .GAP_CYCLES   (GAP),
      .ACK_TIMEOUT  (TMO),
      .CNT_W        (CNT_W)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start_dispense (start_dispense),
      .amount         (amount),
      .hopper_empty   (hopper_empty),
      .coin_ack       (coin_ack),
      .eject          (eject),
      .busy           (busy),
      .done           (done),
      .fault          (fault),
      .remaining      (remaining),
      .coins_paid     (coins_paid)
   );

   coin_select #(.CNT_W(CNT_W)) u_sel (
      .remaining_i    (sel_rem),
      .hopper_empty_i (sel_empty),
      .valid_o        (sel_valid),
      .tube_o         (sel_tube),
      .denom_o        (sel_denom)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Starts a payout and runs it cycle by cycle until done/fault or the budget expires.
   task automatic payout(input int amt, input logic [2:0] empty, input bit ack_en,
                         input int budget, input int restart_c, input int restart_amt,
                         output int end_c, output int busy_n, output logic [2:0] ej_or);
      int         s;
      int         w;
      logic [2:0] prev;
      exp_t       cur;
      s      = -100;
      w      = 0;
      prev   = 3'b000;
      cur.ej = 3'b000;
      cur.rem = 0;
      busy_n = 0;
      ej_or  = 3'b000;
      end_c  = -1;
      @(negedge clk);
      start_dispense = 1'b1;
      amount         = amt[CNT_W-1:0];
      hopper_empty   = empty;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         start_dispense = 1'b0;
         coin_ack       = 1'b0;
         if (busy) busy_n++;
         ej_or = ej_or | eject;
         if (eject != 3'b000 && prev == 3'b000) begin
            s = c;
            w = 0;
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_strobe: got eject=%b expected none", eject);
            end else begin
               cur = sb.pop_front();
               chk("eject_code", int'(eject), int'(cur.ej));
            end
         end
         if (eject != 3'b000) w++;
         if (eject == 3'b000 && prev != 3'b000) begin
            chk("strobe_width", w, PULSE);
            chk("remaining_after_coin", int'(remaining), cur.rem);
         end
         if (ack_en && eject != 3'b000 && (c == s + 1 || c == s + 2)) coin_ack = 1'b1;
         if (c == restart_c) begin
            start_dispense = 1'b1;
            amount         = restart_amt[CNT_W-1:0];
         end
         prev = eject;
         if (done || fault) begin
            end_c = c;
            break;
         end
      end
      coin_ack       = 1'b0;
      start_dispense = 1'b0;
      if (end_c < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL payout_budget: got no done/fault within %0d cycles expected completion", budget);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         end_c;
      int         busy_n;
      logic [2:0] ej_or;

      vecs[0]  = '{0,   3'b000, 1'b0, 3'b000, 0};
      vecs[1]  = '{1,   3'b000, 1'b1, 3'b001, 1};
      vecs[2]  = '{2,   3'b000, 1'b1, 3'b010, 2};
      vecs[3]  = '{4,   3'b000, 1'b1, 3'b010, 2};
      vecs[4]  = '{5,   3'b000, 1'b1, 3'b100, 5};
      vecs[5]  = '{8,   3'b000, 1'b1, 3'b100, 5};
      vecs[6]  = '{255, 3'b000, 1'b1, 3'b100, 5};
      vecs[7]  = '{4,   3'b010, 1'b1, 3'b001, 1};
      vecs[8]  = '{7,   3'b100, 1'b1, 3'b010, 2};
      vecs[9]  = '{3,   3'b011, 1'b0, 3'b000, 0};
      vecs[10] = '{1,   3'b001, 1'b0, 3'b000, 0};
      vecs[11] = '{6,   3'b111, 1'b0, 3'b000, 0};
      vecs[12] = '{5,   3'b100, 1'b1, 3'b010, 2};
      vecs[13] = '{1,   3'b110, 1'b1, 3'b001, 1};

      rst            = 1'b1;
      start_dispense = 1'b0;
      amount         = '0;
      hopper_empty   = 3'b000;
      coin_ack       = 1'b0;
      sel_rem        = '0;
      sel_empty      = 3'b000;

      repeat (3) @(negedge clk);
      chk("reset_eject", int'(eject), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_fault", int'(fault), 0);
      chk("reset_remaining", int'(remaining), 0);
      chk("reset_coins_paid", int'(coins_paid), 0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         sel_rem   = vecs[i].rem[CNT_W-1:0];
         sel_empty = vecs[i].empty;
         #1;
         chk("sel_valid", int'(sel_valid), int'(vecs[i].valid));
         chk("sel_tube", int'(sel_tube), int'(vecs[i].tube));
         chk("sel_denom", int'(sel_denom), vecs[i].denom);
      end

      // greedy payout of 8 with every tube stocked
      sb.push_back('{3'b100, 3});
      sb.push_back('{3'b010, 1});
      sb.push_back('{3'b001, 0});
      payout(8, 3'b000, 1'b1, 200, -1, 0, end_c, busy_n, ej_or);
      chk("t1_done", int'(done), 1);
      chk("t1_done_cycle", end_c, 32);
      chk("t1_fault", int'(fault), 0);
      chk("t1_remaining", int'(remaining), 0);
      chk("t1_coins_paid", int'(coins_paid), 3);
      chk("t1_queue_drained", sb.size(), 0);
      @(negedge clk);
      chk("t1_done_single", int'(done), 0);
      chk("t1_busy_after", int'(busy), 0);

      // 2-unit tube empty: four 1-unit coins
      repeat (4) sb.push_back('{3'b001, 0});
      sb[0].rem = 3; sb[1].rem = 2; sb[2].rem = 1;
      payout(4, 3'b010, 1'b1, 200, -1, 0, end_c, busy_n, ej_or);
      chk("t2_done", int'(done), 1);
      chk("t2_no_tube2", int'(ej_or[1]), 0);
      chk("t2_remaining", int'(remaining), 0);
      chk("t2_coins_paid", int'(coins_paid), 4);
      chk("t2_queue_drained", sb.size(), 0);

      // no usable tube: immediate shortfall
      payout(3, 3'b011, 1'b1, 50, -1, 0, end_c, busy_n, ej_or);
      chk("t3_fault", int'(fault), 1);
      chk("t3_fault_cycle", end_c, 2);
      chk("t3_remaining", int'(remaining), 3);
      chk("t3_coins_paid", int'(coins_paid), 0);
      chk("t3_no_strobe", int'(ej_or), 0);
      chk("t3_busy_cycles", busy_n, 1);
      repeat (3) @(negedge clk);
      chk("t3_fault_sticky", int'(fault), 1);
      chk("t3_no_done", int'(done), 0);

      // hopper never acknowledges: timeout fault, then a fresh payout recovers
      sb.push_back('{3'b100, 5});
      payout(5, 3'b000, 1'b0, 200, -1, 0, end_c, busy_n, ej_or);
      chk("t4_fault", int'(fault), 1);
      chk("t4_fault_cycle", end_c, 2 + TMO);
      chk("t4_remaining", int'(remaining), 5);
      chk("t4_coins_paid", int'(coins_paid), 0);
      sb.push_back('{3'b001, 0});
      payout(1, 3'b000, 1'b1, 100, -1, 0, end_c, busy_n, ej_or);
      chk("t4b_done", int'(done), 1);
      chk("t4b_fault_cleared", int'(fault), 0);
      chk("t4b_remaining", int'(remaining), 0);
      chk("t4b_coins_paid", int'(coins_paid), 1);

      // zero amount
      payout(0, 3'b000, 1'b1, 20, -1, 0, end_c, busy_n, ej_or);
      chk("t5_done", int'(done), 1);
      chk("t5_done_cycle", end_c, 2);
      chk("t5_busy_cycles", busy_n, 1);
      chk("t5_no_strobe", int'(ej_or), 0);
      @(negedge clk);
      chk("t5_done_single", int'(done), 0);

      // reset on the second strobe cycle
      @(negedge clk);
      start_dispense = 1'b1;
      amount         = 8'd7;
      hopper_empty   = 3'b000;
      @(negedge clk);
      start_dispense = 1'b0;
      @(negedge clk);
      chk("t6_first_strobe", int'(eject), 4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_eject_cleared", int'(eject), 0);
      chk("t6_busy_cleared", int'(busy), 0);
      chk("t6_remaining_cleared", int'(remaining), 0);
      rst = 1'b0;

      // start pulse while busy must not re-sample amount
      sb.push_back('{3'b100, 2});
      sb.push_back('{3'b010, 0});
      payout(7, 3'b000, 1'b1, 200, 1, 2, end_c, busy_n, ej_or);
      chk("t7_done", int'(done), 1);
      chk("t7_remaining", int'(remaining), 0);
      chk("t7_coins_paid", int'(coins_paid), 2);
      chk("t7_queue_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
